// File: rtl/dict_create_if.sv
// Request/status and dictionary-memory signals of the word header writer.
// The slave side is the writer; the master side is the requester plus the memory.
interface dict_create_if #(
    parameter int ASZ = 17,
    parameter int DSZ = 8
);
    logic           start;
    logic [ASZ-1:0] ai;
    logic [4:0]     len;
    logic           imm;

    logic [ASZ-1:0] mem_a;
    logic           mem_we;
    logic [DSZ-1:0] mem_vo;
    logic [DSZ-1:0] mem_vi;

    logic           bsy;
    logic           done;
    logic           err;
    logic [ASZ-1:0] ctx;
    logic [ASZ-1:0] here;

    modport master (
        output start, ai, len, imm, mem_vi,
        input  mem_a, mem_we, mem_vo, bsy, done, err, ctx, here
    );

    modport slave (
        input  start, ai, len, imm, mem_vi,
        output mem_a, mem_we, mem_vo, bsy, done, err, ctx, here
    );
endinterface

// File: rtl/dict_create.sv
// Appends a linked word header at here and links it in as ctx; done lands 4+2*len cycles after start.
// No backpressure: start is only taken in IDLE, ignored while busy, and bad requests pulse err.
module dict_create #(
    parameter int             DSZ   = 8,
    parameter int             ASZ   = 17,
    parameter logic [ASZ-1:0] CTX0  = ASZ'('h2b),
    parameter logic [ASZ-1:0] HERE0 = ASZ'('h100)
) (
    input  logic         clk,
    input  logic         rst,
    dict_create_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LNK0,
        S_LNK1,
        S_LEN,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [ASZ-1:0] ctx_q, ctx_d;
    logic [ASZ-1:0] here_q, here_d;
    logic [ASZ-1:0] ai_q, ai_d;
    logic [4:0]     len_q, len_d;
    logic [4:0]     i_q, i_d;
    logic           imm_q, imm_d;
    logic           err_q, err_d;

    logic [ASZ-1:0] mem_a;
    logic           mem_we;
    logic [DSZ-1:0] mem_vo;
    logic           bsy;
    logic           done;

    logic [ASZ:0]   last_a;
    logic           reject;

    // Last byte the header would occupy, one bit wider so an overrun shows as a carry.
    assign last_a = {1'b0, here_q} + (ASZ+1)'(bus.len) + (ASZ+1)'(2);
    assign reject = (bus.len == 5'd0)
                 || last_a[ASZ]
                 || ((here_q >> 16) != '0)
                 || (here_q[15:0] == 16'hffff);

    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        here_d  = here_q;
        ai_d    = ai_q;
        len_d   = len_q;
        i_d     = i_q;
        imm_d   = imm_q;
        err_d   = 1'b0;
        mem_a   = '0;
        mem_we  = 1'b0;
        mem_vo  = '0;
        bsy     = 1'b1;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                bsy = 1'b0;
                if (bus.start) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        ai_d    = bus.ai;
                        len_d   = bus.len;
                        imm_d   = bus.imm;
                        i_d     = 5'd0;
                        state_d = S_LNK0;
                    end
                end
            end
            S_LNK0: begin
                mem_we  = 1'b1;
                mem_a   = here_q;
                mem_vo  = DSZ'(ctx_q[7:0]);
                state_d = S_LNK1;
            end
            S_LNK1: begin
                mem_we  = 1'b1;
                mem_a   = here_q + ASZ'(1);
                mem_vo  = DSZ'(ctx_q[15:8]);
                state_d = S_LEN;
            end
            S_LEN: begin
                mem_we  = 1'b1;
                mem_a   = here_q + ASZ'(2);
                mem_vo  = DSZ'({imm_q, 2'b00, len_q});
                state_d = S_RD;
            end
            S_RD: begin
                mem_a   = ai_q + ASZ'(i_q);
                state_d = S_WR;
            end
            S_WR: begin
                // Read data for byte i arrives now, one cycle after its address in RD.
                mem_we = 1'b1;
                mem_a  = here_q + ASZ'(3) + ASZ'(i_q);
                mem_vo = bus.mem_vi;
                if (i_q == len_q - 5'd1) begin
                    ctx_d   = here_q;
                    here_d  = here_q + ASZ'(3) + ASZ'(len_q);
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 5'd1;
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                bsy     = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ctx_q   <= CTX0;
            here_q  <= HERE0;
            ai_q    <= '0;
            len_q   <= '0;
            i_q     <= '0;
            imm_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            here_q  <= here_d;
            ai_q    <= ai_d;
            len_q   <= len_d;
            i_q     <= i_d;
            imm_q   <= imm_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_a  = mem_a;
    assign bus.mem_we = mem_we;
    assign bus.mem_vo = mem_vo;
    assign bus.bsy    = bsy;
    assign bus.done   = done;
    assign bus.err    = err_q;
    assign bus.ctx    = ctx_q;
    assign bus.here   = here_q;
endmodule

// File: tb/tb_dict_create.sv
// Directed bench: builds a small dictionary through dict_create and checks every write against a scoreboard.
module tb_dict_create;
    localparam int ASZ = 17;
    localparam int DSZ = 8;

    typedef struct packed {
        logic [ASZ-1:0] a;
        logic [DSZ-1:0] d;
    } wr_t;

    logic clk;
    logic rst;

    dict_create_if #(.ASZ(ASZ), .DSZ(DSZ)) m_if ();
    dict_create_if #(.ASZ(ASZ), .DSZ(DSZ)) t_if ();
    dict_create_if #(.ASZ(ASZ), .DSZ(DSZ)) f_if ();

    dict_create #(.DSZ(DSZ), .ASZ(ASZ), .CTX0(17'h2b), .HERE0(17'h100))
        u_main (.clk(clk), .rst(rst), .bus(m_if));
    dict_create #(.DSZ(DSZ), .ASZ(ASZ), .CTX0(17'h2b), .HERE0(17'h1fffe))
        u_top  (.clk(clk), .rst(rst), .bus(t_if));
    dict_create #(.DSZ(DSZ), .ASZ(ASZ), .CTX0(17'h2b), .HERE0(17'hffff))
        u_ffff (.clk(clk), .rst(rst), .bus(f_if));

    logic [7:0]     mem [0:(1<<ASZ)-1];
    logic           bd_we;
    logic [ASZ-1:0] bd_a;
    logic [7:0]     bd_d;

    wr_t  exp_q[$];
    int   checks;
    int   errors;
    int   m_we_cnt, t_we_cnt, f_we_cnt, m_done_cnt;
    logic [ASZ-1:0] exp_ctx, exp_here;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dictionary memory: write-first-cycle sampling, registered read (1-cycle latency).
    always @(posedge clk) begin
        if (bd_we) mem[bd_a] <= bd_d;
        else if (m_if.mem_we) mem[m_if.mem_a] <= m_if.mem_vo;
        m_if.mem_vi <= mem[m_if.mem_a];
    end

    always @(negedge clk) begin
        if (m_if.mem_we === 1'b1) begin
            m_we_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed a=%h d=%h required none", m_if.mem_a, m_if.mem_vo);
            end
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                checks++;
                assert ({m_if.mem_a, m_if.mem_vo} === {e.a, e.d}) else begin
                    errors++;
                    $error("FAIL write observed a=%h d=%h required a=%h d=%h", m_if.mem_a, m_if.mem_vo, e.a, e.d);
                end
            end
        end
        if (m_if.done === 1'b1) m_done_cnt++;
        if (t_if.mem_we === 1'b1) t_we_cnt++;
        if (f_if.mem_we === 1'b1) f_we_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [ASZ-1:0] a, input logic [7:0] d);
        bd_a  = a;
        bd_d  = d;
        bd_we = 1'b1;
        step();
        bd_we = 1'b0;
    endtask

    task automatic load_str(input logic [ASZ-1:0] a, input string s);
        for (int i = 0; i < s.len(); i++) poke(a + ASZ'(i), s[i]);
    endtask

    // Walks the linked headers from head looking for an exact name match.
    function automatic logic find(input logic [ASZ-1:0] head, input string nm);
        logic [ASZ-1:0] a;
        logic           hit;
        logic           ok;
        int             l;
        a   = head;
        hit = 1'b0;
        for (int it = 0; it < 16; it++) begin
            if (!hit && a[15:0] != 16'hffff) begin
                l  = int'(mem[a + ASZ'(2)] & 8'h1f);
                ok = (l == nm.len());
                for (int j = 0; j < l && ok; j++)
                    if (mem[a + ASZ'(3 + j)] != nm[j]) ok = 1'b0;
                if (ok) hit = 1'b1;
                a = {1'b0, mem[a + ASZ'(1)], mem[a]};
            end
        end
        return hit;
    endfunction

    task automatic create(input logic [ASZ-1:0] ai, input string nm, input logic imm,
                          input int exp_done, input int poke_cyc);
        int n;
        int k;
        n = nm.len();
        exp_q.push_back({exp_here,            exp_ctx[7:0]});
        exp_q.push_back({exp_here + ASZ'(1),  exp_ctx[15:8]});
        exp_q.push_back({exp_here + ASZ'(2),  imm, 2'b00, 5'(n)});
        for (int i = 0; i < n; i++) exp_q.push_back({exp_here + ASZ'(3 + i), nm[i]});
        m_if.ai    = ai;
        m_if.len   = 5'(n);
        m_if.imm   = imm;
        m_if.start = 1'b1;
        step();
        m_if.start = 1'b0;
        k = 1;
        while (m_if.done !== 1'b1 && k < 80) begin
            m_if.start = (k == poke_cyc);
            if (k == poke_cyc) m_if.len = 5'd7;
            step();
            m_if.start = 1'b0;
            k++;
        end
        chk($sformatf("done_cycle_%s", nm), k, exp_done);
        chk($sformatf("bsy_in_done_%s", nm), m_if.bsy, 1'b0);
        chk($sformatf("ctx_after_%s", nm), m_if.ctx, exp_here);
        chk($sformatf("here_after_%s", nm), m_if.here, exp_here + ASZ'(3 + n));
        exp_ctx  = exp_here;
        exp_here = exp_here + ASZ'(3 + n);
        step();
        chk($sformatf("done_one_cycle_%s", nm), m_if.done, 1'b0);
    endtask

    initial begin
        int we0, dn0;
        checks = 0; errors = 0;
        m_we_cnt = 0; t_we_cnt = 0; f_we_cnt = 0; m_done_cnt = 0;
        bd_we = 1'b0; bd_a = '0; bd_d = '0;
        m_if.start = 1'b0; m_if.ai = '0; m_if.len = '0; m_if.imm = 1'b0;
        t_if.start = 1'b0; t_if.ai = '0; t_if.len = '0; t_if.imm = 1'b0; t_if.mem_vi = '0;
        f_if.start = 1'b0; f_if.ai = '0; f_if.len = '0; f_if.imm = 1'b0; f_if.mem_vi = '0;
        rst = 1'b0;
        step();
        step();
        // Prebuilt head word "OK" at 'h2b terminates the chain; TIB strings follow.
        poke(17'h2b, 8'hff);
        poke(17'h2c, 8'hff);
        poke(17'h2d, 8'h02);
        load_str(17'h2e,   "OK");
        load_str(17'h1000, "DUP");
        load_str(17'h1010, "X");
        load_str(17'h1020, "AB");

        chk("rst_ctx",    m_if.ctx,    17'h2b);
        chk("rst_here",   m_if.here,   17'h100);
        chk("rst_bsy",    m_if.bsy,    1'b0);
        chk("rst_done",   m_if.done,   1'b0);
        chk("rst_err",    m_if.err,    1'b0);
        chk("rst_mem_we", m_if.mem_we, 1'b0);
        chk("rst_mem_a",  m_if.mem_a,  17'h0);
        chk("rst_mem_vo", m_if.mem_vo, 8'h0);
        chk("rst_top_here",  t_if.here, 17'h1fffe);
        chk("rst_ffff_here", f_if.here, 17'hffff);
        rst = 1'b1;
        exp_ctx  = 17'h2b;
        exp_here = 17'h100;
        step();

        create(17'h1000, "DUP", 1'b0, 10, 0);
        create(17'h1010, "X",   1'b1, 6,  0);
        chk("ctx_chain",  m_if.ctx,  17'h106);
        chk("here_chain", m_if.here, 17'h10a);
        chk("find_DUP", find(m_if.ctx, "DUP"), 1'b1);
        chk("find_X",   find(m_if.ctx, "X"),   1'b1);
        chk("find_OK",  find(m_if.ctx, "OK"),  1'b1);
        chk("find_FOO", find(m_if.ctx, "FOO"), 1'b0);

        // len==0 rejected on the main instance.
        we0 = m_we_cnt;
        m_if.ai = 17'h1000; m_if.len = 5'd0; m_if.imm = 1'b0; m_if.start = 1'b1;
        step();
        m_if.start = 1'b0;
        chk("len0_err",  m_if.err,  1'b1);
        chk("len0_bsy",  m_if.bsy,  1'b0);
        step();
        chk("len0_err_clear", m_if.err,  1'b0);
        chk("len0_ctx",       m_if.ctx,  17'h106);
        chk("len0_here",      m_if.here, 17'h10a);
        chk("len0_writes",    m_we_cnt - we0, 0);

        // Header would run past the top of memory.
        t_if.ai = 17'h1000; t_if.len = 5'd2; t_if.start = 1'b1;
        step();
        t_if.start = 1'b0;
        chk("top_err", t_if.err, 1'b1);
        step();
        chk("top_err_clear", t_if.err,  1'b0);
        chk("top_ctx",       t_if.ctx,  17'h2b);
        chk("top_here",      t_if.here, 17'h1fffe);
        chk("top_writes",    t_we_cnt, 0);

        // 'hffff is the empty-link sentinel and can never be a header address.
        f_if.ai = 17'h1000; f_if.len = 5'd1; f_if.start = 1'b1;
        step();
        f_if.start = 1'b0;
        chk("ffff_err", f_if.err, 1'b1);
        step();
        chk("ffff_err_clear", f_if.err,  1'b0);
        chk("ffff_ctx",       f_if.ctx,  17'h2b);
        chk("ffff_here",      f_if.here, 17'hffff);
        chk("ffff_writes",    f_we_cnt, 0);

        // Second start arrives while the first create is in RD.
        dn0 = m_done_cnt;
        create(17'h1020, "AB", 1'b0, 8, 4);
        repeat (4) step();
        chk("busy_single_done", m_done_cnt - dn0, 1);
        chk("busy_find_AB", find(m_if.ctx, "AB"), 1'b1);

        // Reset during the first WR cycle of a create.
        dn0 = m_done_cnt;
        exp_q.push_back({exp_here,           exp_ctx[7:0]});
        exp_q.push_back({exp_here + ASZ'(1), exp_ctx[15:8]});
        exp_q.push_back({exp_here + ASZ'(2), 8'h03});
        exp_q.push_back({exp_here + ASZ'(3), 8'h44});
        m_if.ai = 17'h1000; m_if.len = 5'd3; m_if.imm = 1'b0; m_if.start = 1'b1;
        step();
        m_if.start = 1'b0;
        repeat (4) step();
        chk("abort_in_wr", m_if.mem_a, exp_here + ASZ'(3));
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        chk("abort_ctx",  m_if.ctx,  17'h2b);
        chk("abort_here", m_if.here, 17'h100);
        chk("abort_bsy",  m_if.bsy,  1'b0);
        repeat (12) step();
        chk("abort_no_done",     m_done_cnt - dn0, 0);
        chk("abort_writes_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
